// File: rtl/branch_trace_buffer_if.sv
// Branch event stream in, FIFO read port and status out; clk/reset stay plain ports.
interface branch_trace_buffer_if #(parameter int AW = 4);
  logic        clear;
  logic        ev_valid;
  logic [31:0] ev_pc;
  logic        ev_taken;
  logic        ev_slot_nop;
  logic        ev_slot_auto;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic        rd_taken;
  logic [1:0]  rd_slot_kind;
  logic [15:0] rd_seq;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic [15:0] drop_count;

  modport master (
    output clear, ev_valid, ev_pc, ev_taken, ev_slot_nop, ev_slot_auto, rd_ready,
    input  rd_valid, rd_pc, rd_taken, rd_slot_kind, rd_seq, count, full, empty, drop_count
  );

  modport slave (
    input  clear, ev_valid, ev_pc, ev_taken, ev_slot_nop, ev_slot_auto, rd_ready,
    output rd_valid, rd_pc, rd_taken, rd_slot_kind, rd_seq, count, full, empty, drop_count
  );
endinterface

// File: rtl/branch_trace_buffer.sv
// Sequence-tagged branch event FIFO, first-word fall-through read, one push/pop per cycle.
// Events arriving while full (and not popping) are dropped and counted with saturation.
module branch_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic                i_clk,
  input logic                i_reset,
  branch_trace_buffer_if.slave bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  kind;
    logic [15:0] seq;
  } entry_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [1:0]    w_kind;
  entry_t        w_wr_entry;
  entry_t        w_head;

  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push  = bus.ev_valid && (!w_full || w_pop);
  assign w_drop  = bus.ev_valid && w_full && !w_pop;

  always_comb begin
    w_kind = 2'd0;
    if (bus.ev_slot_nop) begin
      w_kind = 2'd2;
    end else if (bus.ev_slot_auto) begin
      w_kind = 2'd1;
    end
  end

  assign w_wr_entry = '{pc: bus.ev_pc, taken: bus.ev_taken, kind: w_kind, seq: r_seq};

  always_ff @(posedge i_clk) begin
    if (w_push && !bus.clear) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else if (bus.clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_seq    <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      // Sequence advances on dropped events too, leaving a visible gap.
      if (bus.ev_valid) begin
        r_seq <= r_seq + 16'd1;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.rd_valid     = !w_empty;
  assign bus.rd_pc        = w_head.pc;
  assign bus.rd_taken     = w_head.taken;
  assign bus.rd_slot_kind = w_head.kind;
  assign bus.rd_seq       = w_head.seq;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.drop_count   = r_drop;
endmodule

// File: tb/tb_branch_trace_buffer.sv
// Self-checking bench: scoreboard queue plus vector table and directed corner sequences.
module tb_branch_trace_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [1:0]  kind;
    logic [15:0] seq;
  } ent_t;

  typedef struct {
    bit          ev;
    logic [31:0] pc;
    bit          tk;
    bit          nop;
    bit          au;
    bit          rdy;
    int          exp_count;
    int          exp_kind;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  branch_trace_buffer_if #(.AW(AW)) bus();
  branch_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  ent_t        mq[$];
  logic [15:0] m_seq  = '0;
  logic [15:0] m_drop = '0;

  logic        s_valid;
  logic [AW:0] s_count;
  logic [1:0]  s_kind;
  logic [15:0] s_seq;
  logic        s_full;
  logic        s_empty;
  logic [15:0] s_drop;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_seq  = '0;
    m_drop = '0;
  endtask

  // Drive one cycle, sample at the falling edge, then advance the model.
  task automatic do_cycle(input bit ev, input logic [31:0] pc, input bit tk, input bit nop,
                          input bit au, input bit rdy, input bit clr);
    ent_t e;
    bit   pop;
    bit   push;
    int   sz;
    bus.ev_valid     = ev;
    bus.ev_pc        = pc;
    bus.ev_taken     = tk;
    bus.ev_slot_nop  = nop;
    bus.ev_slot_auto = au;
    bus.rd_ready     = rdy;
    bus.clear        = clr;
    @(negedge clk);
    sz      = mq.size();
    s_valid = bus.rd_valid;
    s_count = bus.count;
    s_kind  = bus.rd_slot_kind;
    s_seq   = bus.rd_seq;
    s_full  = bus.full;
    s_empty = bus.empty;
    s_drop  = bus.drop_count;
    check("status", {bus.rd_valid, bus.count, bus.full, bus.empty, bus.drop_count},
          {sz != 0, (AW+1)'(sz), sz == DEPTH, sz == 0, m_drop});
    pop = (sz != 0) && rdy && !clr;
    if (pop) begin
      check("read_data", {bus.rd_pc, bus.rd_taken, bus.rd_slot_kind, bus.rd_seq}, mq[0]);
    end
    if (clr) begin
      model_reset();
    end else begin
      push = ev && ((sz < DEPTH) || pop);
      if (ev && !push && (m_drop != 16'hFFFF)) m_drop++;
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.pc    = pc;
        e.taken = tk;
        e.kind  = nop ? 2'd2 : (au ? 2'd1 : 2'd0);
        e.seq   = m_seq;
        mq.push_back(e);
      end
      if (ev) m_seq++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.clear = 0; bus.ev_valid = 0; bus.ev_pc = '0; bus.ev_taken = 0;
    bus.ev_slot_nop = 0; bus.ev_slot_auto = 0; bus.rd_ready = 0;
    #1 rst = 1'b1;
    #2;
    check("reset_state", {bus.rd_valid, bus.empty, bus.full, bus.count, bus.drop_count},
          {1'b0, 1'b1, 1'b0, 5'd0, 16'd0});
    @(posedge clk); #1;
    rst = 1'b0;

    // Four iterations of the bne loop at 0x14, last one falls through.
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 32'h14, i < 3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("loop_count", s_count, 4);
    check("loop_drop", s_drop, 0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("loop_seq", s_seq, i);
      check("loop_taken", s_valid && s_count != 0, 1);
    end

    tbl[0] = '{1, 32'h100, 1, 0, 0, 0, 0, -1};
    tbl[1] = '{1, 32'h104, 0, 0, 1, 0, 1, -1};
    tbl[2] = '{1, 32'h108, 1, 1, 0, 0, 2, -1};
    tbl[3] = '{1, 32'h10c, 0, 1, 1, 0, 3, -1};
    tbl[4] = '{0, 32'h0,   0, 0, 0, 1, 4, 0};
    tbl[5] = '{0, 32'h0,   0, 0, 0, 1, 3, 1};
    tbl[6] = '{0, 32'h0,   0, 0, 0, 1, 2, 2};
    tbl[7] = '{0, 32'h0,   0, 0, 0, 1, 1, 2};
    for (int i = 0; i < 8; i++) begin
      do_cycle(tbl[i].ev, tbl[i].pc, tbl[i].tk, tbl[i].nop, tbl[i].au, tbl[i].rdy, 1'b0);
      check("tbl_count", s_count, tbl[i].exp_count);
      if (tbl[i].exp_kind >= 0) begin
        check("tbl_valid", s_valid, 1);
        check("tbl_kind", s_kind, tbl[i].exp_kind);
      end
    end

    // Overflow: 20 events into 16 entries.
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("ovf_full", s_full, 1);
    check("ovf_count", s_count, 16);
    check("ovf_drop", s_drop, 4);
    for (int i = 0; i < 16; i++) begin
      idle(1'b1);
      check("ovf_seq", s_seq, i);
    end
    idle(1'b0);
    check("ovf_empty", s_empty, 1);
    check("ovf_drop_hold", s_drop, 4);

    // Clear together with an event: event discarded, seq restarts.
    do_cycle(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("clr_count", s_count, 0);
    check("clr_drop", s_drop, 0);
    do_cycle(1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("clr_valid", s_valid, 1);
    check("clr_seq", s_seq, 0);

    // Full FIFO with simultaneous push and pop.
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 32'h400 + 32'(4*i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 32'hABC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fpp_pop_seq", s_seq, 0);
    idle(1'b0);
    check("fpp_count", s_count, 16);
    check("fpp_drop", s_drop, 0);
    for (int i = 0; i < 16; i++) begin
      idle(1'b1);
      check("fpp_seq", s_seq, i + 1);
    end

    // Pointer wrap with continuous draining.
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 32'h1000 + 32'(4*i), i[0], 1'b0, 1'b0, 1'b1, 1'b0);
      check("wrap_count_le1", s_count <= 1, 1);
      if (i > 0) check("wrap_seq", s_seq, i - 1);
    end
    idle(1'b1);
    check("wrap_last_seq", s_seq, 39);
    check("wrap_drop", s_drop, 0);

    // Asynchronous reset mid-stream, with drops pending.
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) do_cycle(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {bus.rd_valid, bus.empty, bus.full, bus.count, bus.drop_count},
          {1'b0, 1'b1, 1'b0, 5'd0, 16'd0});
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    do_cycle(1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    check("post_reset_seq", s_seq, 0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
